// File: rtl/hex_scan_driver.sv
// Multiplexed hex-digit scanner with double-buffered value, per-digit blank and decimal point.
// Optional leading-zero suppression is enabled by defining HEX_LZ_SUPPRESS_EN.
module hex_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic                    Load,
    input  logic [NUM_DIGITS-1:0]   DpIn,
    input  logic [NUM_DIGITS-1:0]   BlankIn,
    output logic [6:0]              Seg,
    output logic                    Dp,
    output logic [NUM_DIGITS-1:0]   DigitSel,
    output logic                    FrameTick
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Segment patterns are active-low, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

`ifdef HEX_LZ_SUPPRESS_EN
    // Position of the most significant nonzero nibble; 0 when the whole value is zero.
    function automatic logic [IDX_W-1:0] msd_index(input logic [W-1:0] v);
        logic [IDX_W-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'h0) begin
                m = IDX_W'(i);
            end
        end
        return m;
    endfunction
`endif

    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [W-1:0]          shadow_q, shadow_d;
    logic [W-1:0]          disp_q, disp_d;
    logic                  pend_q, pend_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  tick_q, tick_d;

    logic                  div_wrap;
    logic                  frame_wrap;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  cur_dp;
    logic                  lz_blank;
    logic [NUM_DIGITS-1:0] onehot;

    always_comb begin
        div_wrap   = (div_q == DIV_LAST);
        frame_wrap = div_wrap && (idx_q == IDX_LAST);
        div_d      = div_wrap ? '0 : div_q + 1'b1;
        idx_d      = idx_q;
        if (div_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // A Load landing on the wrap edge bypasses the shadow so it shows in the frame just starting.
    always_comb begin
        shadow_d = shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        if (Load && frame_wrap) begin
            disp_d = Value;
            pend_d = 1'b0;
        end else if (Load) begin
            shadow_d = Value;
            pend_d   = 1'b1;
        end else if (frame_wrap && pend_q) begin
            disp_d = shadow_q;
            pend_d = 1'b0;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_blank = BlankIn[i];
                cur_dp    = DpIn[i];
                onehot[i] = 1'b1;
            end
        end
`ifdef HEX_LZ_SUPPRESS_EN
        lz_blank = (idx_q > msd_index(disp_q));
`else
        lz_blank = 1'b0;
`endif
        seg_d  = (cur_blank || lz_blank) ? 7'b1111111 : glyph(cur_nib);
        dp_d   = ~cur_dp;
        sel_d  = ~onehot;
        tick_d = frame_wrap;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
            sel_q    <= '1;
            tick_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            sel_q    <= sel_d;
            tick_q   <= tick_d;
        end
    end

    assign Seg       = seg_q;
    assign Dp        = dp_q;
    assign DigitSel  = sel_q;
    assign FrameTick = tick_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Randomised scoreboard bench for hex_scan_driver (4 digits, 4-cycle scan period).
module tb_hex_scan_driver;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int FRAME = N * D;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  sel;
    logic        tick;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int          k_m = 0;
    logic [15:0] disp_m = 16'h0;
    logic [15:0] shadow_m = 16'h0;
    bit          pend_m = 1'b0;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    hex_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(D)) dut (
        .Clk(clk),
        .Reset(rst),
        .Value(value),
        .Load(load),
        .DpIn(dp_in),
        .BlankIn(blank_in),
        .Seg(seg),
        .Dp(dp),
        .DigitSel(sel),
        .FrameTick(tick)
    );

    always #5 clk = ~clk;

    function automatic exp_t view(input int idx, input logic [15:0] disp,
                                 input logic [3:0] blank, input logic [3:0] dpr);
        exp_t       v;
        logic [3:0] nib;
        bit         lz;
        int         msd;
        nib = 4'((disp >> (4 * idx)) & 16'hF);
        lz  = 1'b0;
        msd = 0;
`ifdef HEX_LZ_SUPPRESS_EN
        for (int j = 0; j < N; j++) begin
            if (((disp >> (4 * j)) & 16'hF) != 0) msd = j;
        end
        lz = (idx > msd);
`endif
        v.seg  = (blank[idx] || lz) ? 7'b1111111 : glyph_tab[nib];
        v.dp   = ~dpr[idx];
        v.sel  = ~(4'b0001 << idx);
        v.tick = 1'b0;
        return v;
    endfunction

    // Reference model: everything follows from the cycle count since reset release.
    initial begin
        exp_t e;
        bit   wrap;
        forever begin
            @(posedge clk);
            if (rst) begin
                e.seg  = 7'b1111111;
                e.dp   = 1'b1;
                e.sel  = 4'b1111;
                e.tick = 1'b0;
                k_m      = 0;
                disp_m   = 16'h0;
                shadow_m = 16'h0;
                pend_m   = 1'b0;
            end else begin
                e    = view((k_m / D) % N, disp_m, blank_in, dp_in);
                k_m  = k_m + 1;
                wrap = (k_m % FRAME) == 0;
                e.tick = wrap;
                if (load && wrap) begin
                    disp_m = value;
                    pend_m = 1'b0;
                end else if (load) begin
                    shadow_m = value;
                    pend_m   = 1'b1;
                end else if (wrap && pend_m) begin
                    disp_m = shadow_m;
                    pend_m = 1'b0;
                end
            end
            q.push_back(e);
        end
    end

    // Monitor: one expected entry per clock, compared on the falling edge.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                got.seg  = seg;
                got.dp   = dp;
                got.sel  = sel;
                got.tick = tick;
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL scan @%0t: got seg=%b dp=%b sel=%b tick=%b, expected seg=%b dp=%b sel=%b tick=%b",
                             $time, got.seg, got.dp, got.sel, got.tick, e.seg, e.dp, e.sel, e.tick);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Return at a falling edge such that the next rising edge is cycle r of the frame.
    task automatic align(input int r);
        for (int i = 0; i < 2 * FRAME && ((k_m + 1) % FRAME) != r; i++) begin
            @(negedge clk);
        end
        vectors++;
        if (((k_m + 1) % FRAME) != r) begin
            miscompares++;
            $display("FAIL align: frame phase %0d, required %0d", (k_m + 1) % FRAME, r);
        end
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(2);

        pulse_load(16'h1234);
        cyc(3 * FRAME);

        align(FRAME - 2);
        value = 16'hABCD;
        load  = 1'b1;
        @(negedge clk);
        value = 16'h5678;
        @(negedge clk);
        load  = 1'b0;
        cyc(2 * FRAME);

        align(0);
        pulse_load(16'h9E0F);
        cyc(2 * FRAME);

        blank_in = 4'b0100;
        dp_in    = 4'b0001;
        cyc(2 * FRAME);
        blank_in = 4'b0000;
        dp_in    = 4'b0000;

        pulse_load(16'h0050);
        cyc(2 * FRAME);

        align(5);
        pulse_load(16'h4321);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2 * FRAME);

        for (int i = 0; i < 800; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) blank_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        load = 1'b0;
        rst  = 1'b0;
        cyc(FRAME + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 Parameter: NUM_DIGITS, 4, number of multiplexed hex digits (range 1..8).
REQ-002 Parameter: SCAN_DIV, 1000, clock cycles each digit is driven (range 2..2^20).
REQ-003 Port: Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: Reset  in  1  synchronous, active-high reset.
REQ-005 Port: Value  in  4*NUM_DIGITS  hex value; digit i is bits [4i+3:4i], digit 0 least significant.
REQ-006 Port: Load  in  1  single-cycle strobe that captures Value.
REQ-007 Port: DpIn  in  NUM_DIGITS  decimal-point request per digit, active-high; sampled live, not double-buffered.
REQ-008 Port: BlankIn  in  NUM_DIGITS  per-digit forced blank, active-high; sampled live.
REQ-009 Port: Seg  out  7  segment drive, active-low, bit 0 = a through bit 6 = g.
REQ-010 Port: Dp  out  1  decimal point, active-low.
REQ-011 Port: DigitSel  out  NUM_DIGITS  digit enable, one-hot active-low (exactly one bit 0 when scanning).
REQ-012 Port: FrameTick  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Function
REQ-013 Glyph table, hex 0..F -> Seg: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-014 Blank digit: Seg = 1111111; Dp is still driven from DpIn.
REQ-015 Divider counter: counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and digit index advances by 1.
REQ-016 Digit index: wraps NUM_DIGITS-1 -> 0; FrameTick asserts in the cycle the index register becomes 0 by wrap, never on reset exit.
REQ-017 Outputs are registered: Seg/Dp/DigitSel reflect the index one cycle after the index changes; no combinational path from any input to any output.
REQ-018 Double buffer: Load writes Value into shadow register and sets Pending.
REQ-019 At each frame wrap, if Pending=1 the display register takes the shadow and Pending clears; otherwise the display register holds.
REQ-020 Load coincident with a frame wrap: the display register takes the new Value directly in that cycle; Pending stays 0.
REQ-021 Multiple Loads within one frame: the last one wins; earlier values are never displayed.
REQ-022 A digit with BlankIn[i]=1 is blanked regardless of value.
REQ-023 NUM_DIGITS=1: index stays 0; FrameTick pulses on every divider wrap.

Reset
REQ-024 Reset clears the divider, index, shadow, display register and Pending to 0.
REQ-025 During reset and the first cycle after release: Seg=1111111, Dp=1, DigitSel all 1, FrameTick=0.
REQ-026 Reset asserted mid-frame takes effect at the next edge and discards any Pending value.

Configuration
REQ-027 Macro HEX_LZ_SUPPRESS_EN defined: every digit above the most significant nonzero digit of the display register is blanked; digit 0 is always shown; DpIn is unaffected.
REQ-028 HEX_LZ_SUPPRESS_EN undefined: all digits are shown, including leading zeros.

Verification
REQ-029 NUM_DIGITS=4, SCAN_DIV=4; reset, then Load Value=16'h1234 -> after the next FrameTick, digits 0..3 show Seg 0011001, 0110000, 0100100, 1111001, each for 4 cycles, with DigitSel 1110, 1101, 1011, 0111.
REQ-030 Load 16'hABCD two cycles before a frame wrap, then Load 16'h5678 one cycle before it -> 16'hABCD is never displayed; 16'h5678 appears from the wrap onward.
REQ-031 Load coincident with the FrameTick wrap cycle -> the new value is shown on digit 0 in the same frame; Pending reads 0.
REQ-032 With HEX_LZ_SUPPRESS_EN, Value=16'h0050 -> digits 3 and 2 show 1111111, digit 1 shows 0010010, digit 0 shows 1000000; without the macro, digits 3 and 2 show 1000000.
REQ-033 Assert Reset mid-frame with Pending=1 -> the next cycle shows blank outputs, and after release all digits show 0 (1000000).
REQ-034 BlankIn=4'b0100, DpIn=4'b0001 -> digit 2 is blank, and Dp=0 only while DigitSel=1110.
